// File: rtl/fx3_test_pkg.sv
// Shared types and pin-index constants for the FX3 interface test block.
package fx3_test_pkg;

    localparam int DATA_W = 23;
    localparam int DQ_W   = 16;
    localparam int CTRL_W = 4;
    localparam int SYNC_W = DATA_W + CTRL_W;

    // Input pin positions inside the sampled vector
    localparam int IDX_WRN        = 16;
    localparam int IDX_RDN        = 17;
    localparam int IDX_FL_B       = 18;
    localparam int IDX_PENDN      = 19;
    localparam int IDX_ADDR1      = 20;
    localparam int IDX_MEM_CLK    = 21;
    localparam int IDX_MEM_DO_TXD = 22;

    // Output pin positions inside the loopback vector
    localparam int IDX_CSN     = 16;
    localparam int IDX_OEN     = 17;
    localparam int IDX_FL_A    = 18;
    localparam int IDX_GPIO25  = 19;
    localparam int IDX_FL_C    = 20;
    localparam int IDX_ADDR0   = 21;
    localparam int IDX_MEM_SSN = 22;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        WAIT_READY = 2'd1,
        IDLE       = 2'd2,
        WAIT_ACK   = 2'd3
    } state_e;

endpackage

// File: rtl/fx3_sync.sv
// Two-flop synchroniser, parameterised width, synchronous active-high reset.
module fx3_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_d, meta_q;
    logic [W-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/top_test_fx3.sv
// FX3 interface test: reset sequencing, GPIF clock, snapshot loopback with interrupt.
// Optional macro TEST_PATTERN_EN: free-running counter on out while reporting is disabled.
module top_test_fx3
    import fx3_test_pkg::*;
#(
    parameter int RST_CYCLES = 16,
    parameter int PCLK_DIV   = 2
) (
    input  logic            CLK_40,
    input  logic            ARST,
    input  logic            FX3_GPIO26,
    input  logic            FX3_GPIO57,
    input  logic            PLL_LOCK,
    input  logic            FX3_MEM_DI_RXD,
    input  logic [DQ_W-1:0] FX3_DQ_IN,
    input  logic            FX3_WRn,
    input  logic            FX3_RDn,
    input  logic            FX3_FL_B,
    input  logic            FX3_PENDn,
    input  logic            FX3_ADDR1,
    input  logic            FX3_MEM_CLK,
    input  logic            FX3_MEM_DO_TXD,
    output logic            FX3_GPIO23,
    output logic            FX3_PCLK,
    output logic            FX3_RST,
    output logic [DQ_W-1:0] FX3_DQ_OUT,
    output logic            FX3_CSn,
    output logic            FX3_OEn,
    output logic            FX3_FL_A,
    output logic            FX3_GPIO25,
    output logic            FX3_FL_C,
    output logic            FX3_ADDR0,
    output logic            FX3_MEM_SSN
);

    localparam int LCW  = $clog2(RST_CYCLES + 1);
    localparam int HALF = PCLK_DIV / 2;
    localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [DATA_W-1:0] in_raw, in_s;
    logic              ack_s, en_s, lock_s, rdy_s;

    always_comb begin
        in_raw                 = '0;
        in_raw[DQ_W-1:0]       = FX3_DQ_IN;
        in_raw[IDX_WRN]        = FX3_WRn;
        in_raw[IDX_RDN]        = FX3_RDn;
        in_raw[IDX_FL_B]       = FX3_FL_B;
        in_raw[IDX_PENDN]      = FX3_PENDn;
        in_raw[IDX_ADDR1]      = FX3_ADDR1;
        in_raw[IDX_MEM_CLK]    = FX3_MEM_CLK;
        in_raw[IDX_MEM_DO_TXD] = FX3_MEM_DO_TXD;
    end

    fx3_sync #(.W(SYNC_W)) u_sync (
        .clk (CLK_40),
        .rst (ARST),
        .d_i ({FX3_MEM_DI_RXD, PLL_LOCK, FX3_GPIO57, FX3_GPIO26, in_raw}),
        .q_o ({rdy_s, lock_s, en_s, ack_s, in_s})
    );

    state_e            state_d, state_q;
    logic [LCW-1:0]    lock_cnt_d, lock_cnt_q;
    logic [DATA_W-1:0] prev_d, prev_q;
    logic [DATA_W-1:0] out_d, out_q;
    logic              intr_d, intr_q;
    logic              rst_d, rst_q;
    logic              pclk_d, pclk_q;
    logic [PW-1:0]     pclk_cnt_d, pclk_cnt_q;
`ifdef TEST_PATTERN_EN
    logic [DATA_W-1:0] cnt_d, cnt_q;
`endif

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        prev_d     = prev_q;
        out_d      = out_q;
        intr_d     = intr_q;
        rst_d      = rst_q;
`ifdef TEST_PATTERN_EN
        cnt_d      = cnt_q + 1'b1;
`endif
        case (state_q)
            RESET_HOLD: begin
                out_d  = '0;
                intr_d = 1'b0;
                rst_d  = 1'b0;
                prev_d = '0;
                if (lock_s) begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                    if (lock_cnt_d == LCW'(RST_CYCLES)) begin
                        rst_d   = 1'b1;
                        state_d = WAIT_READY;
                    end
                end else begin
                    lock_cnt_d = '0;
                end
            end
            WAIT_READY: begin
                out_d = '0;
                if (rdy_s) begin
                    prev_d  = in_s;
                    state_d = IDLE;
`ifdef TEST_PATTERN_EN
                    cnt_d   = '0;
`endif
                end
            end
            IDLE: begin
                prev_d = in_s;
                if ((in_s != prev_q) && en_s && !ack_s) begin
                    out_d   = in_s;
                    intr_d  = 1'b1;
                    state_d = WAIT_ACK;
                end
`ifdef TEST_PATTERN_EN
                else if (!en_s) begin
                    out_d = cnt_q;
                end
`endif
            end
            WAIT_ACK: begin
                if (ack_s) begin
                    intr_d  = 1'b0;
                    prev_d  = in_s;
                    state_d = IDLE;
`ifdef TEST_PATTERN_EN
                    cnt_d   = '0;
`endif
                end
            end
            default: state_d = RESET_HOLD;
        endcase

        // Lock loss outranks every in-state decision and mirrors reset outputs
        if ((state_q != RESET_HOLD) && !lock_s) begin
            state_d    = RESET_HOLD;
            lock_cnt_d = '0;
            prev_d     = '0;
            out_d      = '0;
            intr_d     = 1'b0;
            rst_d      = 1'b0;
        end
    end

    // Held low while FX3 is (or is about to be) in reset; first toggle lands high
    always_comb begin
        pclk_d     = pclk_q;
        pclk_cnt_d = pclk_cnt_q;
        if (!rst_q || !rst_d) begin
            pclk_d     = 1'b0;
            pclk_cnt_d = '0;
        end else if (pclk_cnt_q == '0) begin
            pclk_d     = ~pclk_q;
            pclk_cnt_d = PW'(HALF - 1);
        end else begin
            pclk_cnt_d = pclk_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK_40) begin
        if (ARST) begin
            state_q    <= RESET_HOLD;
            lock_cnt_q <= '0;
            prev_q     <= '0;
            out_q      <= '0;
            intr_q     <= 1'b0;
            rst_q      <= 1'b0;
            pclk_q     <= 1'b0;
            pclk_cnt_q <= '0;
`ifdef TEST_PATTERN_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            prev_q     <= prev_d;
            out_q      <= out_d;
            intr_q     <= intr_d;
            rst_q      <= rst_d;
            pclk_q     <= pclk_d;
            pclk_cnt_q <= pclk_cnt_d;
`ifdef TEST_PATTERN_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign FX3_GPIO23  = intr_q;
    assign FX3_PCLK    = pclk_q;
    assign FX3_RST     = rst_q;
    assign FX3_DQ_OUT  = out_q[DQ_W-1:0];
    assign FX3_CSn     = out_q[IDX_CSN];
    assign FX3_OEn     = out_q[IDX_OEN];
    assign FX3_FL_A    = out_q[IDX_FL_A];
    assign FX3_GPIO25  = out_q[IDX_GPIO25];
    assign FX3_FL_C    = out_q[IDX_FL_C];
    assign FX3_ADDR0   = out_q[IDX_ADDR0];
    assign FX3_MEM_SSN = out_q[IDX_MEM_SSN];

endmodule

// File: tb/tb_top_test_fx3.sv
// Directed + randomized bench for top_test_fx3 against a transaction-level loopback model.
module tb_top_test_fx3;

    localparam int RST_CYCLES = 16;
    localparam int PCLK_DIV   = 2;
    localparam int HALF       = PCLK_DIV / 2;
    localparam int SETTLE     = 5;

    logic        CLK_40 = 1'b0;
    logic        ARST, ack, en, lock, rdy;
    logic [22:0] vin;
    logic        FX3_GPIO23, FX3_PCLK, FX3_RST;
    logic [15:0] FX3_DQ_OUT;
    logic        FX3_CSn, FX3_OEn, FX3_FL_A, FX3_GPIO25, FX3_FL_C, FX3_ADDR0, FX3_MEM_SSN;
    logic [22:0] vout;

    assign vout = {FX3_MEM_SSN, FX3_ADDR0, FX3_FL_C, FX3_GPIO25, FX3_FL_A, FX3_OEn, FX3_CSn, FX3_DQ_OUT};

    always #5 CLK_40 = ~CLK_40;

    top_test_fx3 #(.RST_CYCLES(RST_CYCLES), .PCLK_DIV(PCLK_DIV)) dut (
        .CLK_40         (CLK_40),
        .ARST           (ARST),
        .FX3_GPIO26     (ack),
        .FX3_GPIO57     (en),
        .PLL_LOCK       (lock),
        .FX3_MEM_DI_RXD (rdy),
        .FX3_DQ_IN      (vin[15:0]),
        .FX3_WRn        (vin[16]),
        .FX3_RDn        (vin[17]),
        .FX3_FL_B       (vin[18]),
        .FX3_PENDn      (vin[19]),
        .FX3_ADDR1      (vin[20]),
        .FX3_MEM_CLK    (vin[21]),
        .FX3_MEM_DO_TXD (vin[22]),
        .FX3_GPIO23     (FX3_GPIO23),
        .FX3_PCLK       (FX3_PCLK),
        .FX3_RST        (FX3_RST),
        .FX3_DQ_OUT     (FX3_DQ_OUT),
        .FX3_CSn        (FX3_CSn),
        .FX3_OEn        (FX3_OEn),
        .FX3_FL_A       (FX3_FL_A),
        .FX3_GPIO25     (FX3_GPIO25),
        .FX3_FL_C       (FX3_FL_C),
        .FX3_ADDR0      (FX3_ADDR0),
        .FX3_MEM_SSN    (FX3_MEM_SSN)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: last reported vector, interrupt, awaiting-ack flag, last seen input
    logic [22:0] m_prev, m_out;
    logic        m_intr, m_wait;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK_40);
        #1;
    endtask

    function automatic void predict(input logic [22:0] v, input logic e, input logic a);
        if (m_wait) begin
            if (a) begin
                m_wait = 1'b0;
                m_intr = 1'b0;
                m_prev = v;
            end
        end else begin
            if (v != m_prev && e && !a) begin
                m_out  = v;
                m_intr = 1'b1;
                m_wait = 1'b1;
            end
            m_prev = v;
        end
    endfunction

    task automatic apply(input logic [22:0] v, input logic e, input logic a,
                         input bit chk_out, input string tag);
        vin = v; en = e; ack = a;
        step(SETTLE);
        predict(v, e, a);
        if (chk_out) check({tag, ".out"}, {9'd0, vout}, {9'd0, m_out});
        check({tag, ".intr"}, {31'd0, FX3_GPIO23}, {31'd0, m_intr});
    endtask

    initial begin
        logic [22:0] v;
        logic        e, a;
        ARST = 1'b1; ack = 1'b0; en = 1'b0; lock = 1'b0; rdy = 1'b0; vin = '0;
        step(2);
        check("rst.fx3_rst", {31'd0, FX3_RST}, 32'd0);
        check("rst.pclk", {31'd0, FX3_PCLK}, 32'd0);
        check("rst.out", {9'd0, vout}, 32'd0);
        check("rst.intr", {31'd0, FX3_GPIO23}, 32'd0);

        // FX3 reset release: 2 sync cycles plus RST_CYCLES locked cycles
        ARST = 1'b0; lock = 1'b1;
        step(RST_CYCLES + 1);
        check("lock.held", {31'd0, FX3_RST}, 32'd0);
        step(1);
        check("lock.release", {31'd0, FX3_RST}, 32'd1);
        check("lock.pclk0", {31'd0, FX3_PCLK}, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            check($sformatf("pclk.%0d", k), {31'd0, FX3_PCLK}, {31'd0, (((k - 1) / HALF) % 2) == 0});
        end

        // Ready with reporting on; the input at IDLE entry is absorbed
        rdy = 1'b1; en = 1'b1;
        step(SETTLE);
        check("ready.out", {9'd0, vout}, 32'd0);
        check("ready.intr", {31'd0, FX3_GPIO23}, 32'd0);
        m_prev = vin; m_out = '0; m_intr = 1'b0; m_wait = 1'b0;

        // Loopback latency: nothing after two edges, snapshot after the third
        vin = 23'd77777;
        step(2);
        check("lat.early.out", {9'd0, vout}, 32'd0);
        check("lat.early.intr", {31'd0, FX3_GPIO23}, 32'd0);
        step(1);
        predict(vin, 1'b1, 1'b0);
        check("lat.out", {9'd0, vout}, 32'h12FD1);
        check("lat.intr", {31'd0, FX3_GPIO23}, 32'd1);
        step(2);

        apply(23'd55555, 1'b1, 1'b0, 1, "frozen");
        check("frozen.const", {9'd0, vout}, 32'h12FD1);
        apply(23'd55555, 1'b1, 1'b1, 1, "ack");
        apply(23'd55555, 1'b1, 1'b0, 1, "reload");
        check("reload.const", {9'd0, vout}, 32'h12FD1);
        apply(23'd1, 1'b1, 1'b0, 1, "next");
        check("next.const", {9'd0, vout}, 32'h1);
        apply(23'd1, 1'b1, 1'b1, 1, "next.ack");
        apply(23'd1, 1'b1, 1'b0, 1, "next.rel");

`ifdef TEST_PATTERN_EN
        begin
            logic [22:0] c0;
            apply(23'h2AAAAA, 1'b0, 1'b0, 0, "gate");
            c0 = vout;
            step(1);
            check("pat.inc1", {9'd0, vout}, {9'd0, c0 + 23'd1});
            step(1);
            check("pat.inc2", {9'd0, vout}, {9'd0, c0 + 23'd2});
        end
`else
        apply(23'h2AAAAA, 1'b0, 1'b0, 1, "gate");
        check("gate.const", {9'd0, vout}, 32'h1);
`endif
        apply(23'h0F0F0F, 1'b1, 1'b0, 1, "regate");
        apply(23'h0F0F0F, 1'b1, 1'b1, 1, "regate.ack");
        apply(23'h0F0F0F, 1'b1, 1'b0, 1, "regate.rel");

        for (int i = 0; i < 40; i++) begin
            v = ($urandom_range(0, 1) == 1) ? 23'($urandom()) : vin;
            e = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 9) < 3);
`ifdef TEST_PATTERN_EN
            e = 1'b1;
`endif
            apply(v, e, a, 1, $sformatf("rnd%0d", i));
        end

        // Lock loss while an interrupt is outstanding
        if (!m_wait) apply(~vin, 1'b1, 1'b0, 1, "pre_loss");
        check("pre_loss.intr", {31'd0, FX3_GPIO23}, 32'd1);
        lock = 1'b0;
        step(3);
        check("loss.fx3_rst", {31'd0, FX3_RST}, 32'd0);
        check("loss.intr", {31'd0, FX3_GPIO23}, 32'd0);
        check("loss.out", {9'd0, vout}, 32'd0);
        check("loss.pclk", {31'd0, FX3_PCLK}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
